// File: rtl/joy_serial_scan.sv
// Serial joystick scanner for daisy-chained PISO pads on the UserIO port.
// Define JOY_SERIAL_DEBOUNCE_EN to require two identical frames per player update.
module joy_serial_scan #(
    parameter int PLAYERS   = 2,
    parameter int BITS      = 12,
    parameter int CLK_DIV   = 20,
    parameter int GAP_TICKS = 64
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*16-1:0]   joystick,
    output logic [PLAYERS-1:0]      present,
    output logic                    frame_valid
);

    localparam int TOTAL = PLAYERS * BITS;
    localparam int CW    = $clog2(TOTAL);
    localparam int DW    = $clog2(CLK_DIV);
    localparam int GW    = $clog2(GAP_TICKS + 1);

    localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL - 1);
    localparam logic [DW-1:0] DIV_TOP  = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_TOP  = GW'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLK_LO,
        CLK_HI,
        GAP
    } state_t;

    state_t                  state;
    logic [DW-1:0]           div_cnt;
    logic [CW-1:0]           bit_cnt;
    logic [GW-1:0]           gap_cnt;
    logic [TOTAL-1:0]        raw;
    logic                    tick;

    logic [PLAYERS*16-1:0]   joy_next;
    logic [PLAYERS-1:0]      pres_next;
    logic [BITS-1:0]         slice;
    logic [15:0]             inv16;
    logic                    take;

`ifdef JOY_SERIAL_DEBOUNCE_EN
    logic [TOTAL-1:0]        prev_raw;
    logic                    hist_ok;
`endif

    assign tick = enable && (div_cnt == DIV_TOP);

    always_ff @(posedge clk_sys) begin
        if (!reset_n || !enable) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // All-zero raw slice means every line pulled low: no pad or a shorted cable.
    always_comb begin
        joy_next  = joystick;
        pres_next = present;
        slice     = '0;
        inv16     = '0;
        take      = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            slice = raw[p*BITS +: BITS];
            inv16 = '0;
            inv16[BITS-1:0] = ~slice;
`ifdef JOY_SERIAL_DEBOUNCE_EN
            take = hist_ok && (slice == prev_raw[p*BITS +: BITS]);
`else
            take = 1'b1;
`endif
            if (take) begin
                pres_next[p]         = |slice;
                joy_next[p*16 +: 16] = (|slice) ? inv16 : 16'h0000;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state       <= IDLE;
            joy_clk     <= 1'b1;
            joy_load    <= 1'b1;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            raw         <= '0;
            joystick    <= '0;
            present     <= '0;
            frame_valid <= 1'b0;
`ifdef JOY_SERIAL_DEBOUNCE_EN
            prev_raw    <= '0;
            hist_ok     <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                joy_clk  <= 1'b1;
                joy_load <= 1'b1;
                bit_cnt  <= '0;
                gap_cnt  <= '0;
            end else if (tick) begin
                unique case (state)
                    IDLE: begin
                        state    <= LOAD;
                        joy_load <= 1'b0;
                        bit_cnt  <= '0;
                    end
                    LOAD: begin
                        state    <= CLK_LO;
                        joy_load <= 1'b1;
                        joy_clk  <= 1'b0;
                    end
                    CLK_LO: begin
                        raw[bit_cnt] <= joy_data;
                        joy_clk      <= 1'b1;
                        state        <= CLK_HI;
                    end
                    CLK_HI: begin
                        if (bit_cnt == LAST_BIT) begin
                            state       <= GAP;
                            gap_cnt     <= '0;
                            joystick    <= joy_next;
                            present     <= pres_next;
                            frame_valid <= 1'b1;
`ifdef JOY_SERIAL_DEBOUNCE_EN
                            prev_raw    <= raw;
                            hist_ok     <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                            joy_clk <= 1'b0;
                            state   <= CLK_LO;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_TOP) begin
                            state    <= LOAD;
                            joy_load <= 1'b0;
                            bit_cnt  <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        joy_clk  <= 1'b1;
                        joy_load <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/joy_serial_scan.md
# joy_serial_scan

Parametrised serial joystick scanner for the UserIO port. It shifts out the daisy-chained parallel-in/serial-out joystick adaptor state for 1–4 players with a configurable bit count per player. It publishes debounced-ready, active-high button vectors in the `joystick_0` bit layout to the `emu` top level, replacing the fixed two-player DB15 reader. It adds per-player presence detection and a frame-valid strobe.

## Interface
Parameters:
- `PLAYERS`, 2, number of chained pads (1–4).
- `BITS`, 12, serial bits per pad (8–16); the first bit shifted is joystick bit 0.
- `CLK_DIV`, 20, `clk_sys` cycles per half-period of `joy_clk` (≥2).
- `GAP_TICKS`, 64, idle half-periods between frames (≥1).

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  scanning allowed (driven by status bit for UserIO joystick mode).
- `joy_data`  in  1  serial data from the adaptor; active-low button state.
- `joy_clk`  out  1  shift clock to the adaptor; idle high.
- `joy_load`  out  1  parallel-load strobe; active low.
- `joystick`  out  `PLAYERS*16`  active-high buttons; player p occupies `[p*16+15:p*16]`; bits ≥`BITS` are always 0.
- `present`  out  `PLAYERS`  per-player pad detected.
- `frame_valid`  out  1  one-cycle pulse when `joystick`/`present` update.

## Operation
- A tick is asserted every `CLK_DIV` cycles from a free-running divider. The divider resets to 0 and is held at 0 while `enable`=0.
- FSM states: IDLE, LOAD, CLK_LO, CLK_HI, GAP.
- IDLE: `joy_clk`=1, `joy_load`=1. Go to LOAD on the first tick with `enable`=1.
- LOAD: `joy_load`=0 for one tick. Bit counter = 0. Then go to CLK_LO.
- CLK_LO: `joy_clk`=0. On tick, sample `joy_data` into the shift register at index `bit_cnt`, then go to CLK_HI.
- CLK_HI: `joy_clk`=1. On tick, if `bit_cnt`=`PLAYERS*BITS-1`, complete the frame and go to GAP. Otherwise increment `bit_cnt` and go to CLK_LO.
- Bit counter width is `$clog2(PLAYERS*BITS)`. It never wraps mid-frame.
- Frame completion: for each player, take the raw slice `raw[p*BITS +: BITS]`.
  - `present[p]` = 1 unless every raw bit of that slice is 0 (all-pressed means disconnected or shorted).
  - `joystick` slice = `~raw` zero-extended to 16 when `present[p]`=1, else 0.
- GAP: lines idle, counting `GAP_TICKS` ticks, then go to LOAD (or IDLE if `enable`=0).
- When `enable` deasserts in any state, the FSM returns to IDLE on the next cycle. Lines go idle, the partial frame is discarded, and outputs hold their last values.
- Reset mid-frame: everything returns to reset values on the next edge, and no `frame_valid` is emitted.

## Timing
- Reset values: `joy_clk`=1, `joy_load`=1, `joystick`=0, `present`=0, `frame_valid`=0, FSM=IDLE, all counters 0.
- All outputs are registered; `joy_clk`/`joy_load` change only on tick cycles.
- `joy_data` is sampled at the end of the CLK_LO phase, which gives `CLK_DIV` cycles of settle time after the falling edge.
- Frame length = (1 + 2·`PLAYERS`·`BITS` + `GAP_TICKS`)·`CLK_DIV` cycles. With defaults: (1+48+64)·20 = 2260 cycles.
- `frame_valid` pulses on the cycle after the last CLK_HI tick, in the same cycle that `joystick`/`present` change.
- If reset and tick coincide, reset wins.

## Configuration
- `JOY_SERIAL_DEBOUNCE_EN` defined:
  - A player slice updates only when two consecutive completed frames are identical for that player; otherwise it holds its previous value.
  - `frame_valid` still pulses every frame.
  - The first frame after reset never updates outputs.
- Not defined: every completed frame updates outputs directly, with no frame-history storage.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles while `enable`=1 → `joy_clk`=1, `joy_load`=1, `joystick`=0, `present`=0, no `frame_valid`.
- Defaults, model drives player0 bits {0,4} pressed (data low) and player1 bit 8 pressed → after 2260 cycles, `frame_valid` pulses, `joystick`=32'h0100_0011, `present`=2'b11.
- Player1 model drives all 12 bits low → `present`=2'b01 and `joystick[31:16]`=0; player0 is unaffected.
- Waveform check: exactly 24 `joy_clk` falling edges per frame, `joy_load` low for exactly 20 cycles, and a 1280-cycle idle gap.
- `enable` dropped at bit 10 → lines idle within 1 cycle, no `frame_valid`, outputs hold; re-enable → a fresh LOAD follows, with no partial-frame data.
- With `JOY_SERIAL_DEBOUNCE_EN`: alternate player0 bit 4 between frames → outputs never change; hold it stable for 2 frames → `joystick[4]`=1 after the second frame.
